micro_reg_file_mp: RTL

MICRO_REG_FILE_MP -- requirements
Module: micro_reg_file_mp

---
 rtl/micro_reg_file_mp.sv | 93 +++++++++
 1 files changed

// File: rtl/micro_reg_file_mp.sv
// Multi-port register file: one write port and two registered read ports.
// Requests are accepted only in the CPU execute state. Accepted reads return data one cycle later.
module micro_reg_file_mp #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS = 8,
    parameter int STATE_W = 3,
    // EXECUTE1 in the CPU state encoding
    parameter logic [STATE_W-1:0] EXEC_STATE = STATE_W'(2),
    parameter bit ZERO_REG = 1'b0,
    localparam int AW = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset,
    input  logic [STATE_W-1:0]    cpu_state,
    input  logic                  reg_wr_en,
    input  logic [AW-1:0]         reg_wr_sel,
    input  logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic                  reg_rd_en,
    input  logic [AW-1:0]         reg_rd_sel_a,
    input  logic [AW-1:0]         reg_rd_sel_b,
    input  logic                  reg_file_clr,
    output logic [DATA_WIDTH-1:0] reg_rd_data_a,
    output logic [DATA_WIDTH-1:0] reg_rd_data_b,
    output logic                  reg_rd_valid,
    output logic                  reg_addr_err
);

    localparam logic [AW:0] LIMIT = NUM_REGS[AW:0];

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  accept;
    logic                  wr_oor;
    logic                  a_oor;
    logic                  b_oor;
    logic                  wr_hit;
    logic                  rd_hit;
    logic                  err_set;
    logic [DATA_WIDTH-1:0] nxt_a;
    logic [DATA_WIDTH-1:0] nxt_b;

    // Write-first: a same-edge write to the read address is forwarded to the read port.
    function automatic logic [DATA_WIDTH-1:0] read_val(input logic [AW-1:0] sel, input logic oor);
        logic [DATA_WIDTH-1:0] val;
        val = '0;
        if (oor || (ZERO_REG && sel == '0)) begin
            val = '0;
        end else if (wr_hit && reg_wr_sel == sel) begin
            val = reg_wr_data;
        end else begin
            val = regs[sel];
        end
        return val;
    endfunction

    always_comb begin
        accept  = (cpu_state == EXEC_STATE);
        wr_oor  = ({1'b0, reg_wr_sel} >= LIMIT);
        a_oor   = ({1'b0, reg_rd_sel_a} >= LIMIT);
        b_oor   = ({1'b0, reg_rd_sel_b} >= LIMIT);
        wr_hit  = accept && reg_wr_en && !wr_oor && !(ZERO_REG && reg_wr_sel == '0);
        rd_hit  = accept && reg_rd_en;
        err_set = accept && ((reg_wr_en && wr_oor) || (reg_rd_en && (a_oor || b_oor)));
        nxt_a   = read_val(reg_rd_sel_a, a_oor);
        nxt_b   = read_val(reg_rd_sel_b, b_oor);
    end

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            reg_rd_data_a <= '0;
            reg_rd_data_b <= '0;
            reg_rd_valid  <= 1'b0;
            reg_addr_err  <= 1'b0;
        end else if (reg_file_clr) begin
            // Clear overrides any same-edge request, regardless of cpu_state.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            reg_rd_data_a <= '0;
            reg_rd_data_b <= '0;
            reg_rd_valid  <= 1'b0;
            reg_addr_err  <= 1'b0;
        end else begin
            if (wr_hit) regs[reg_wr_sel] <= reg_wr_data;
            if (rd_hit) begin
                reg_rd_data_a <= nxt_a;
                reg_rd_data_b <= nxt_b;
            end
            reg_rd_valid <= rd_hit;
            if (err_set) reg_addr_err <= 1'b1;
        end
    end

endmodule
